// File: rtl/pwm_ctrl_pkg.sv
// Shared types, decode constant and current decode helper for the peak-current PWM controller.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    OFF   = 2'd2,
    FAULT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    PEAK  = 2'd1,
    MAXON = 2'd2,
    ABORT = 2'd3
  } term_t;

  localparam logic [11:0] XOR_7FF = 12'h7FF;
  localparam int unsigned IDN_W   = 11;

  // ADC native format -> signed DN, negative currents clamped to zero.
  function automatic logic [IDN_W-1:0] decode_iest(input logic [11:0] raw);
    logic [11:0] v;
    v = raw ^ XOR_7FF;
    return v[11] ? '0 : v[IDN_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_period_ctr.sv
// Switching-period counter: wraps at PERIOD while enabled, held at zero otherwise.
module pwm_period_ctr #(
  parameter  int unsigned PERIOD = 48,
  localparam int unsigned CW     = $clog2(PERIOD)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  output logic o_wrap_c,
  output logic o_cycle_strobe
);

  logic [CW-1:0] r_pcnt;
  logic          r_strobe;
  logic          w_wrap;

  assign w_wrap         = (r_pcnt == CW'(PERIOD - 1));
  assign o_wrap_c       = w_wrap;
  assign o_cycle_strobe = r_strobe;

  // Strobe marks the first clk of each period that follows a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt   <= '0;
      r_strobe <= 1'b0;
    end else if (i_enable) begin
      r_pcnt   <= w_wrap ? '0 : r_pcnt + CW'(1);
      r_strobe <= w_wrap;
    end else begin
      r_pcnt   <= '0;
      r_strobe <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_peak_ctrl.sv
// Peak-current-mode PWM generator with leading-edge blanking, max on-time and latched overcurrent fault.
module pwm_peak_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD  = 48,
  parameter int unsigned BLANK   = 3,
  parameter int unsigned MAX_ON  = 40,
  parameter logic [11:0] I_FAULT = 12'd2000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        fault_clr,
  input  logic [11:0] i_peak,
  input  logic [11:0] iest_coil,
  output logic        pwm,
  output logic        fault,
  output logic        cycle_strobe,
  output logic [1:0]  term_cause
);

  localparam int unsigned CW = $clog2(PERIOD);

  if (!(BLANK >= 1 && BLANK < MAX_ON && MAX_ON <= PERIOD - 2)) begin : g_cfg_err
    $error("pwm_peak_ctrl: need 1 <= BLANK < MAX_ON <= PERIOD-2");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  term_t             r_term;
  term_t             w_term_nxt;
  logic [CW-1:0]     r_ton;
  logic              r_pwm;
  logic              r_fault;
  logic              w_pwm_nxt;
  logic              w_fault_nxt;
  logic              w_wrap_c;
  logic [IDN_W-1:0]  w_i_dn;
  logic              w_over;
  logic              w_launch;
  logic              w_peak_hit;
  logic              w_ton_max;

  pwm_period_ctr #(.PERIOD(PERIOD)) u_period (
    .clk            (clk),
    .rst_n          (reset_n),
    .i_enable       (enable),
    .o_wrap_c       (w_wrap_c),
    .o_cycle_strobe (cycle_strobe)
  );

  assign w_i_dn     = decode_iest(iest_coil);
  assign w_over     = ({1'b0, w_i_dn} >= I_FAULT);
  assign w_launch   = w_wrap_c && enable && !r_fault && (i_peak != '0);
  assign w_peak_hit = (r_ton >= CW'(BLANK)) && ({1'b0, w_i_dn} >= i_peak);
  assign w_ton_max  = (r_ton == CW'(MAX_ON - 1));

  always_ff @(posedge clk or negedge reset_n) begin : state_reg
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Priority: fault > enable drop > peak > max_on > launch.
  always_comb begin : next_state
    w_state_nxt = r_state;
    w_term_nxt  = r_term;
    if (w_over) begin
      w_state_nxt = FAULT;
      if (r_state == ON) w_term_nxt = ABORT;
    end else begin
      case (r_state)
        IDLE: if (w_launch) w_state_nxt = ON;
        ON: begin
          if (!enable) begin
            w_state_nxt = IDLE;
            w_term_nxt  = ABORT;
          end else if (w_peak_hit) begin
            w_state_nxt = OFF;
            w_term_nxt  = PEAK;
          end else if (w_ton_max) begin
            w_state_nxt = OFF;
            w_term_nxt  = MAXON;
          end
        end
        OFF: begin
          if (!enable)       w_state_nxt = IDLE;
          else if (w_launch) w_state_nxt = ON;
        end
        FAULT: if (fault_clr) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin : output_decode
    w_pwm_nxt   = (w_state_nxt == ON);
    w_fault_nxt = (w_state_nxt == FAULT);
  end

  // ton restarts at zero on every ON entry.
  always_ff @(posedge clk or negedge reset_n) begin : output_reg
    if (!reset_n) begin
      r_pwm   <= 1'b0;
      r_fault <= 1'b0;
      r_term  <= NONE;
      r_ton   <= '0;
    end else begin
      r_pwm   <= w_pwm_nxt;
      r_fault <= w_fault_nxt;
      r_term  <= w_term_nxt;
      r_ton   <= (r_state == ON && w_state_nxt == ON) ? r_ton + CW'(1) : '0;
    end
  end

  assign pwm        = r_pwm;
  assign fault      = r_fault;
  assign term_cause = 2'(r_term);

endmodule
